// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU operand sweeper.
// Holds the sweep state encoding, the fixed operand/result widths, the
// packed sample record carried on out_data and the flag tally helper.
package alu_sweep_pkg;

    localparam int A_W   = 2;   // operand A width
    localparam int B_W   = 4;   // operand B width
    localparam int Y_W   = 4;   // ALU result width
    localparam int REC_W = 14;  // packed record width
    localparam int CNT_W = 7;   // flag tally width, holds 0..64
    localparam int IDX_W = 6;   // combined {A,B} vector index
    localparam int SET_W = 4;   // settle counter width, holds 1..15

    localparam logic [IDX_W-1:0] IDX_LAST = 6'd63;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } sweep_state_t;

    // One sample, MSB first: {a, b, y, zero, neg, carry, ovf}
    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [Y_W-1:0] y;
        logic           z;
        logic           n;
        logic           c;
        logic           o;
    } sweep_rec_t;

    // Add one to a tally when its flag is set; 64 vectors never overflow 7 bits
    function automatic logic [CNT_W-1:0] tally_inc(input logic [CNT_W-1:0] cnt,
                                                   input logic             flag);
        return cnt + {{(CNT_W-1){1'b0}}, flag};
    endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// Loadable down-counter used to hold operands steady before sampling.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - load load_val (takes priority over counting)
//   load_val    - settle length in cycles, 1..15
//   en          - count down by one per cycle, stopping at zero
//   term        - counter currently equals one (the sampling cycle)
module alu_settle_timer
    import alu_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SET_W-1:0] load_val,
    input  logic             en,
    output logic             term
);

    localparam logic [SET_W-1:0] CNT_ONE  = 4'd1;
    localparam logic [SET_W-1:0] CNT_ZERO = 4'd0;

    logic [SET_W-1:0] cnt_r;

    // Counter register: load wins, otherwise step toward zero while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign term = (cnt_r == CNT_ONE);

endmodule

// File: rtl/alu_operand_sweeper.sv
// Stimulus generator and result collector for 2-bit/4-bit operand ALUs.
// Walks {op_a, op_b} through all 64 combinations (A-major), waits
// SETTLE_CYCLES per vector, samples the ALU result and flags into a packed
// record and hands it out on a valid/ready stream. Flag tallies cover the
// most recent sweep.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   start               - begin a sweep (ignored while busy or finishing)
//   busy, done          - sweep in progress / one-cycle completion pulse
//   op_a, op_b          - operands driven to the ALU
//   res_y, res_*        - ALU result and zero/neg/carry/ovf flags
//   out_valid/out_ready - record handshake, out_data = sweep_rec_t
//   *_cnt               - per-sweep flag tallies, 0..64
module alu_operand_sweeper
    import alu_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [A_W-1:0]   op_a,
    output logic [B_W-1:0]   op_b,
    input  logic [Y_W-1:0]   res_y,
    input  logic             res_zero,
    input  logic             res_neg,
    input  logic             res_carry,
    input  logic             res_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REC_W-1:0] out_data,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] neg_cnt,
    output logic [CNT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
        $error("alu_operand_sweeper: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] IDX_ONE   = 6'd1;
    localparam logic [IDX_W-1:0] IDX_ZERO  = 6'd0;
    localparam logic [CNT_W-1:0] CNT_ZERO  = 7'd0;

    sweep_state_t     state_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    sweep_rec_t       rec_r;
    logic             busy_r;
    logic             done_r;
    logic             valid_r;
    logic [A_W-1:0]   op_a_r;
    logic [B_W-1:0]   op_b_r;
    logic [CNT_W-1:0] zero_cnt_r;
    logic [CNT_W-1:0] neg_cnt_r;
    logic [CNT_W-1:0] carry_cnt_r;
    logic [CNT_W-1:0] ovf_cnt_r;

    logic xfer_s;
    logic tmr_load_s;
    logic tmr_en_s;
    logic tmr_term_s;

    // valid_r is only ever high in PRESENT, so this alone marks a transfer
    assign xfer_s    = valid_r & out_ready;
    assign idx_nxt_s = idx_r + IDX_ONE;
    assign tmr_en_s  = (state_r == SETTLE);

    // Reload the settle timer whenever a new vector is put on the operands
    always_comb begin
        tmr_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    tmr_load_s = 1'b1;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            PRESENT: begin
                if (xfer_s && (idx_r != IDX_LAST)) begin
                    tmr_load_s = 1'b1;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    alu_settle_timer u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (SETTLE_LD),
        .en       (tmr_en_s),
        .term     (tmr_term_s)
    );

    // Sweep FSM with index, operand, record and tally registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= IDX_ZERO;
            rec_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            valid_r     <= 1'b0;
            op_a_r      <= 2'd0;
            op_b_r      <= 4'd0;
            zero_cnt_r  <= CNT_ZERO;
            neg_cnt_r   <= CNT_ZERO;
            carry_cnt_r <= CNT_ZERO;
            ovf_cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        idx_r       <= IDX_ZERO;
                        op_a_r      <= 2'd0;
                        op_b_r      <= 4'd0;
                        zero_cnt_r  <= CNT_ZERO;
                        neg_cnt_r   <= CNT_ZERO;
                        carry_cnt_r <= CNT_ZERO;
                        ovf_cnt_r   <= CNT_ZERO;
                        busy_r      <= 1'b1;
                        state_r     <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Sample on the last settle cycle; operands were stable throughout
                    if (tmr_term_s) begin
                        rec_r   <= {op_a_r, op_b_r, res_y,
                                    res_zero, res_neg, res_carry, res_ovf};
                        valid_r <= 1'b1;
                        state_r <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Tallies come from the record actually handed out
                    if (xfer_s) begin
                        valid_r     <= 1'b0;
                        zero_cnt_r  <= tally_inc(zero_cnt_r,  rec_r.z);
                        neg_cnt_r   <= tally_inc(neg_cnt_r,   rec_r.n);
                        carry_cnt_r <= tally_inc(carry_cnt_r, rec_r.c);
                        ovf_cnt_r   <= tally_inc(ovf_cnt_r,   rec_r.o);
                        if (idx_r == IDX_LAST) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= FINISH;
                        end else begin
                            idx_r            <= idx_nxt_s;
                            {op_a_r, op_b_r} <= idx_nxt_s;
                            state_r          <= SETTLE;
                        end
                    end
                end
                FINISH: begin
                    // start is deliberately not looked at here
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign op_a      = op_a_r;
    assign op_b      = op_b_r;
    assign out_valid = valid_r;
    assign out_data  = rec_r;
    assign zero_cnt  = zero_cnt_r;
    assign neg_cnt   = neg_cnt_r;
    assign carry_cnt = carry_cnt_r;
    assign ovf_cnt   = ovf_cnt_r;

endmodule

// File: tb/tb_alu_operand_sweeper.sv
// Self-checking bench for alu_operand_sweeper. Two instances: one with a
// one-cycle settle and a combinational ALU stub, one with a three-cycle
// settle and a stub whose outputs lag the operands by two cycles.
module tb_alu_operand_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // instance 1: SETTLE_CYCLES = 1
    logic        start1, ready1, busy1, done1, valid1;
    logic [1:0]  a1;
    logic [3:0]  b1, y1;
    logic        z1, n1, c1, o1;
    logic [13:0] data1;
    logic [6:0]  zc1, nc1, cc1, oc1;

    // instance 3: SETTLE_CYCLES = 3
    logic        start3, ready3, busy3, done3, valid3;
    logic [1:0]  a3;
    logic [3:0]  b3, y3;
    logic        z3, n3, c3, o3;
    logic [13:0] data3;
    logic [6:0]  zc3, nc3, cc3, oc3;

    // ALU stubs: y = {a, b[1:0]}, zero = (y==0), neg = b[3], carry = b[0], ovf = a[1]
    assign y1 = {a1, b1[1:0]};
    assign z1 = (y1 == 4'd0);
    assign n1 = b1[3];
    assign c1 = b1[0];
    assign o1 = a1[1];

    logic [7:0] raw3_s;
    logic [7:0] dly3_a = 8'd0;
    logic [7:0] dly3_b = 8'd0;
    assign raw3_s = {a3, b3[1:0], ({a3, b3[1:0]} == 4'd0), b3[3], b3[0], a3[1]};
    always @(posedge clk) begin
        dly3_a <= raw3_s;
        dly3_b <= dly3_a;
    end
    assign {y3, z3, n3, c3, o3} = dly3_b;

    alu_operand_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .op_a(a1), .op_b(b1), .res_y(y1), .res_zero(z1), .res_neg(n1),
        .res_carry(c1), .res_ovf(o1), .out_valid(valid1), .out_ready(ready1),
        .out_data(data1), .zero_cnt(zc1), .neg_cnt(nc1), .carry_cnt(cc1),
        .ovf_cnt(oc1)
    );

    alu_operand_sweeper #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .op_a(a3), .op_b(b3), .res_y(y3), .res_zero(z3), .res_neg(n3),
        .res_carry(c3), .res_ovf(o3), .out_valid(valid3), .out_ready(ready3),
        .out_data(data3), .zero_cnt(zc3), .neg_cnt(nc3), .carry_cnt(cc3),
        .ovf_cnt(oc3)
    );

    // Transfer log: a record is taken when valid && ready around the next rising edge
    logic [13:0] rec1_q[$];
    logic [13:0] rec3_q[$];
    int          t3_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && valid1 && ready1) rec1_q.push_back(data1);
        if (rst_n && valid3 && ready3) begin
            rec3_q.push_back(data3);
            t3_q.push_back(cyc);
        end
    end

    // Reference record for vector i, straight from the stub's arithmetic
    function automatic logic [13:0] ref_rec(input int i);
        int a, b, y, v;
        a = i / 16;
        b = i % 16;
        y = a * 4 + (b % 4);
        v = a * 4096 + b * 256 + y * 16
          + ((y == 0) ? 8 : 0) + ((b >= 8) ? 4 : 0) + (b % 2) * 2 + ((a >= 2) ? 1 : 0);
        return v[13:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int ez, en, ec, eo;
        int a, b;

        rst_n = 1'b0; start1 = 1'b0; ready1 = 1'b0; start3 = 1'b0; ready3 = 1'b0;

        // expected per-sweep tallies from the flag rules
        ez = 0; en = 0; ec = 0; eo = 0;
        for (int i = 0; i < 64; i++) begin
            a = i / 16; b = i % 16;
            if (a == 0 && (b % 4) == 0) ez++;
            if (b >= 8) en++;
            if ((b % 2) == 1) ec++;
            if (a >= 2) eo++;
        end

        // reset and idle
        #3;
        chk("reset_outs", {busy1, done1, valid1, a1, b1, data1, zc1, nc1, cc1, oc1}, 64'd0);
        #20 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle%0d", i),
                {busy1, done1, valid1, a1, b1, data1, zc1, nc1, cc1, oc1}, 64'd0);
        end

        // basic sweep, settle 1, ready tied high
        ready1 = 1'b1;
        rec1_q.delete();
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("busy_at_start", busy1, 64'd1);
        chk("valid_1edge", valid1, 64'd0);
        tick();
        chk("valid_2edge", valid1, 64'd1);
        chk("first_rec", data1, 64'(14'b00_0000_0000_1000));
        n = 1;
        while (!done1 && n < 400) begin tick(); n++; end
        chk("done_latency", n, 64'd128);
        chk("busy_at_done", busy1, 64'd0);
        chk("rec_count1", rec1_q.size(), 64'd64);
        for (int i = 0; i < 64 && i < rec1_q.size(); i++)
            chk($sformatf("rec1_%0d", i), rec1_q[i], ref_rec(i));
        chk("zero_cnt", zc1, ez);
        chk("neg_cnt", nc1, en);
        chk("carry_cnt", cc1, ec);
        chk("ovf_cnt", oc1, eo);
        chk("ops_hold", {a1, b1}, 64'd63);
        tick();
        chk("done_pulse", done1, 64'd0);

        // back-to-back start the cycle after done, back-pressure, start while busy
        rec1_q.delete();
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("restart_busy", busy1, 64'd1);
        chk("restart_cnts", {zc1, nc1, cc1, oc1}, 64'd0);
        chk("restart_ops", {a1, b1}, 64'd0);
        n = 0;
        while (!(valid1 && rec1_q.size() == 5) && n < 100) begin tick(); n++; end
        chk("bp_reach", (n < 100), 64'd1);
        ready1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("bp_data%0d", i), data1, ref_rec(5));
            chk($sformatf("bp_valid%0d", i), valid1, 64'd1);
            chk($sformatf("bp_opb%0d", i), b1, 64'd5);
        end
        ready1 = 1'b1;
        n = 0;
        while (rec1_q.size() < 10 && n < 100) begin tick(); n++; end
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("start_ignored", busy1, 64'd1);
        n = 0;
        while (!done1 && n < 1000) begin tick(); n++; end
        chk("done2_seen", done1, 64'd1);
        chk("rec_count2", rec1_q.size(), 64'd64);
        for (int i = 0; i < 64 && i < rec1_q.size(); i++)
            chk($sformatf("rec2_%0d", i), rec1_q[i], ref_rec(i));
        chk("cnts2", {zc1, nc1, cc1, oc1}, {7'(ez), 7'(en), 7'(ec), 7'(eo)});
        tick();

        // reset in the middle of a sweep while record 30 is presented
        rec1_q.delete();
        start1 = 1'b1; tick(); start1 = 1'b0;
        n = 0;
        while (!(valid1 && rec1_q.size() == 30) && n < 200) begin tick(); n++; end
        ready1 = 1'b0;
        chk("mid_valid", valid1, 64'd1);
        chk("mid_cnt_nz", (zc1 != 7'd0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {valid1, busy1, zc1, nc1, cc1, oc1}, 64'd0);
        rst_n = 1'b1;
        rec1_q.delete();
        ready1 = 1'b1;
        tick();
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("after_rst_ops", {a1, b1}, 64'd0);
        n = 0;
        while (rec1_q.size() < 3 && n < 50) begin tick(); n++; end
        chk("after_rst_count", (rec1_q.size() >= 3), 64'd1);
        for (int i = 0; i < 3 && i < rec1_q.size(); i++)
            chk($sformatf("after_rst_rec%0d", i), rec1_q[i], ref_rec(i));
        ready1 = 1'b0;

        // settle 3 with a two-cycle late ALU
        ready3 = 1'b1;
        rec3_q.delete(); t3_q.delete();
        start3 = 1'b1; tick(); start3 = 1'b0;
        n = 0;
        while (!done3 && n < 600) begin tick(); n++; end
        chk("done3_latency", n, 64'd256);
        chk("rec_count3", rec3_q.size(), 64'd64);
        for (int i = 0; i < 64 && i < rec3_q.size(); i++)
            chk($sformatf("rec3_%0d", i), rec3_q[i], ref_rec(i));
        for (int i = 1; i < t3_q.size(); i++)
            chk($sformatf("period3_%0d", i), t3_q[i] - t3_q[i-1], 64'd4);
        chk("cnts3", {zc3, nc3, cc3, oc3}, {7'(ez), 7'(en), 7'(ec), 7'(eo)});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
